// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: state encoding,
// grant flags and the fetch/data arbitration helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;
    localparam logic [1:0] ST_IF_DROP = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        IF_BUSY = ST_IF_BUSY,
        DM_BUSY = ST_DM_BUSY,
        IF_DROP = ST_IF_DROP
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    typedef struct packed {
        logic valid;
        logic who;
    } grant_t;

    // On a conflict the requester that did not win last time gets the port.
    function automatic grant_t arbitrate(input logic if_cand,
                                         input logic dm_cand,
                                         input logic last_grant);
        grant_t g;
        g.valid = if_cand | dm_cand;
        if (if_cand && dm_cand)
            g.who = (last_grant == GRANT_IF) ? GRANT_DM : GRANT_IF;
        else if (dm_cand)
            g.who = GRANT_DM;
        else
            g.who = GRANT_IF;
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported instruction/data memory between IF and MEM stages,
// sequencing one request/ack access at a time and raising pipeline stalls.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access outstanding; arbitrate fetch vs data
// IF_BUSY | fetch access in flight; result goes to if_rdata
// DM_BUSY | load/store access in flight; result goes to dm_rdata
// IF_DROP | flushed fetch still in flight; wait for ack, discard result
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                flush,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_fetch,
    output logic                stall_mem
);

    arb_state_t state;
    logic       last_grant;
    logic       if_cand;
    logic       dm_cand;
    logic       ack;
    grant_t     grant;

    // A requester completing this cycle is not re-granted until it has had
    // a chance to drop or change its request.
    assign if_cand = if_req & ~flush & ~if_valid;
    assign dm_cand = dm_req & ~dm_done;
    assign ack     = mem_ack & mem_req;

    always_comb begin
        grant = arbitrate(if_cand, dm_cand, last_grant);
    end

    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = dm_req & ~dm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_rdata   <= '0;
            dm_done    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant.valid) begin
                        mem_req    <= 1'b1;
                        last_grant <= grant.who;
                        if (grant.who == GRANT_DM) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_be    <= dm_be;
                            state     <= DM_BUSY;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '0;
                            state     <= IF_BUSY;
                        end
                    end
                end
                IF_BUSY: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        // A flush landing with the ack kills the result.
                        if (!flush) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= IF_DROP;
                    end
                end
                IF_DROP: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DM_BUSY: begin
                    if (ack) begin
                        mem_req  <= 1'b0;
                        dm_rdata <= mem_rdata;
                        dm_done  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
